// File: rtl/sram_fifo_feeder.sv
// Feeds one producer word per transaction to an SRAM FIFO engine and returns the engine's
// read-back word to a consumer. Define FEEDER_WATCHDOG_EN to bound the engine wait phases.
module sram_fifo_feeder #(
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic        fifoClk,
  input  logic        fifoRst,
  input  logic        inValid,
  input  logic [15:0] inData,
  output logic        inReady,
  output logic        fifoStart,
  output logic [15:0] fifoDataIn,
  input  logic [3:0]  fifoState,
  input  logic [15:0] fifoDataOut,
  output logic        outValid,
  output logic [15:0] outData,
  input  logic        outReady,
  output logic [15:0] txCount,
  output logic        timeoutErr
);

  localparam logic [3:0] EngIdle = 4'd0;
  localparam logic [3:0] EngDone = 4'd7;

  typedef enum logic [1:0] {StIdle, StStart, StRelease, StOut} state_e;

  state_e      state_q, state_d;
  logic        accept, capture, retire, consume, timeout;
  logic        fifo_start_q;
  logic [15:0] fifo_data_in_q;
  logic        out_valid_q;
  logic [15:0] out_data_q;
  logic [15:0] tx_count_q;

  always_ff @(posedge fifoClk) begin
    if (!fifoRst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Only the awaited engine code advances a wait state; anything else is ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (inValid) state_d = StStart;
      end
      StStart: begin
        if (timeout) begin
          state_d = StIdle;
        end else if (fifoState == EngDone) begin
          state_d = StRelease;
        end
      end
      StRelease: begin
        if (timeout) begin
          state_d = StIdle;
        end else if (fifoState == EngIdle) begin
          state_d = StOut;
        end
      end
      StOut: begin
        if (outReady) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    inReady = 1'b0;
    accept  = 1'b0;
    capture = 1'b0;
    retire  = 1'b0;
    consume = 1'b0;
    unique case (state_q)
      StIdle: begin
        inReady = 1'b1;
        accept  = inValid;
      end
      StStart:   capture = (fifoState == EngDone);
      StRelease: retire  = (fifoState == EngIdle);
      StOut:     consume = outReady;
      default: ;
    endcase
  end

  always_ff @(posedge fifoClk) begin
    if (!fifoRst) begin
      fifo_start_q   <= 1'b1;
      fifo_data_in_q <= 16'h0000;
      out_valid_q    <= 1'b0;
      out_data_q     <= 16'h0000;
      tx_count_q     <= 16'h0000;
    end else begin
      if (accept) begin
        fifo_data_in_q <= inData;
        fifo_start_q   <= 1'b0;
      end
      if (capture || timeout) fifo_start_q <= 1'b1;
      if (capture) out_data_q <= fifoDataOut;
      if (retire) begin
        out_valid_q <= 1'b1;
        tx_count_q  <= tx_count_q + 16'd1;
      end
      if (consume) out_valid_q <= 1'b0;
    end
  end

`ifdef FEEDER_WATCHDOG_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);

  logic [WdW-1:0] wd_cnt_q, wd_cnt_d;
  logic           waiting;
  logic           timeout_err_q;

  // Counter restarts on entry to either wait state and advances once per stalled cycle.
  always_comb begin
    waiting  = ((state_q == StStart) && (fifoState != EngDone)) ||
               ((state_q == StRelease) && (fifoState != EngIdle));
    timeout  = waiting && (wd_cnt_q == WdLast);
    wd_cnt_d = wd_cnt_q;
    if (accept || capture || timeout) begin
      wd_cnt_d = '0;
    end else if (waiting) begin
      wd_cnt_d = wd_cnt_q + WdW'(1);
    end
  end

  always_ff @(posedge fifoClk) begin
    if (!fifoRst) begin
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      if (timeout) timeout_err_q <= 1'b1;
    end
  end

  assign timeoutErr = timeout_err_q;
`else
  assign timeout    = 1'b0;
  assign timeoutErr = 1'b0;
`endif

  assign fifoStart  = fifo_start_q;
  assign fifoDataIn = fifo_data_in_q;
  assign outValid   = out_valid_q;
  assign outData    = out_data_q;
  assign txCount    = tx_count_q;

endmodule

// File: tb/tb_sram_fifo_feeder.sv
// Self-checking bench for sram_fifo_feeder: behavioural SRAM engine plus a transaction-level
// reference model (last written word, transaction count, fixed 10-edge latency).
module tb_sram_fifo_feeder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        fifo_start;
  logic [15:0] fifo_data_in;
  logic [3:0]  eng_state;
  logic [15:0] eng_word;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic [15:0] tx_count;
  logic        timeout_err;

  logic        eng_rst;
  logic [3:0]  freeze_at;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] last_word;
  logic [15:0] exp_cnt;

  always #5 clk = ~clk;

  sram_fifo_feeder #(.TIMEOUT_CYCLES(32)) dut (
    .fifoClk    (clk),
    .fifoRst    (rst_n),
    .inValid    (in_valid),
    .inData     (in_data),
    .inReady    (in_ready),
    .fifoStart  (fifo_start),
    .fifoDataIn (fifo_data_in),
    .fifoState  (eng_state),
    .fifoDataOut(eng_word),
    .outValid   (out_valid),
    .outData    (out_data),
    .outReady   (out_ready),
    .txCount    (tx_count),
    .timeoutErr (timeout_err)
  );

  // Engine: start strobe walks 0..7, release returns to 0 and stores the written word,
  // which becomes the read-back of the following transaction.
  always @(posedge clk) begin
    if (eng_rst) begin
      eng_state <= 4'd0;
      eng_word  <= 16'h0000;
    end else if (eng_state != freeze_at) begin
      if (eng_state == 4'd0) begin
        if (!fifo_start) eng_state <= 4'd1;
      end else if (eng_state == 4'd7) begin
        if (fifo_start) begin
          eng_state <= 4'd0;
          eng_word  <= fifo_data_in;
        end
      end else begin
        eng_state <= eng_state + 4'd1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    eng_rst  = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    eng_rst   = 1'b0;
    last_word = 16'h0000;
    exp_cnt   = 16'h0000;
  endtask

  // Called and returns on a falling edge with the feeder idle.
  task automatic do_tx(input logic [15:0] w, input int hold, input bit junk);
    int          k;
    bit          stable;
    logic [15:0] held;
    out_ready = (hold == 0);
    check("ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
    in_valid = 1'b0;
    check("start_low_after_accept", fifo_start, 0);
    check("data_in_latched", fifo_data_in, w);
    stable = 1'b1;
    k = 0;
    while (!out_valid && k < 40) begin
      if (junk) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 16'($urandom);
      end
      @(negedge clk);
      k++;
      if (fifo_data_in !== w || in_ready !== 1'b0) stable = 1'b0;
    end
    in_valid = 1'b0;
    exp_cnt  = exp_cnt + 16'd1;
    check("latency_edges", k, 10);
    check("busy_and_data_stable", stable, 1);
    check("out_data_readback", out_data, last_word);
    check("tx_count", tx_count, exp_cnt);
    held   = out_data;
    stable = 1'b1;
    repeat (hold) begin
      in_valid = 1'b1;
      in_data  = 16'($urandom);
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0 ||
          fifo_start !== 1'b1 || fifo_data_in !== w) stable = 1'b0;
    end
    in_valid = 1'b0;
    check("out_hold_stable", stable, 1);
    out_ready = 1'b1;
    @(negedge clk);
    check("out_valid_dropped", out_valid, 0);
    check("idle_after_out", in_ready, 1);
    out_ready = 1'b0;
    last_word = w;
  endtask

  initial begin
    int k;
    bit stable;
    bit saw_valid;

    // Reset with live inputs: reset must win.
    rst_n     = 1'b0;
    eng_rst   = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'hA5A5;
    out_ready = 1'b1;
    freeze_at = 4'd15;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_fifo_start", fifo_start, 1);
    check("rst_fifo_data_in", fifo_data_in, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_tx_count", tx_count, 0);
    check("rst_timeout_err", timeout_err, 0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b1;
    eng_rst   = 1'b0;
    last_word = 16'h0000;
    exp_cnt   = 16'h0000;
    @(negedge clk);

    do_tx(16'h1234, 0, 1'b0);
    do_tx(16'hBEEF, 5, 1'b1);
    for (int i = 0; i < 8; i++) begin
      do_tx(16'($urandom), int'($urandom_range(0, 4)), 1'b1);
    end

    // Abort in the start phase.
    check("ready_before_abort", in_ready, 1);
    in_valid = 1'b1;
    in_data  = 16'h5A5A;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n   = 1'b0;
    eng_rst = 1'b1;
    @(negedge clk);
    check("abort_fifo_start", fifo_start, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_tx_count", tx_count, 0);
    check("abort_idle", in_ready, 1);
    check("abort_fifo_data_in", fifo_data_in, 0);
    rst_n     = 1'b1;
    eng_rst   = 1'b0;
    last_word = 16'h0000;
    exp_cnt   = 16'h0000;
    stable    = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || fifo_start !== 1'b1) stable = 1'b0;
    end
    check("no_output_after_abort", stable, 1);
    do_tx(16'($urandom), 1, 1'b1);

    // Engine stuck mid-sequence.
    freeze_at = 4'd2;
    check("ready_before_stall", in_ready, 1);
    in_valid = 1'b1;
    in_data  = 16'hC0DE;
    @(negedge clk);
    in_valid = 1'b0;
`ifdef FEEDER_WATCHDOG_EN
    k = 0;
    saw_valid = 1'b0;
    while (!timeout_err && k < 60) begin
      @(negedge clk);
      k++;
      if (out_valid) saw_valid = 1'b1;
    end
    check("wd_wait_cycles", k, 32);
    check("wd_fifo_start", fifo_start, 1);
    check("wd_idle", in_ready, 1);
    check("wd_tx_count", tx_count, exp_cnt);
    check("wd_no_out_valid", saw_valid, 0);
    repeat (3) @(negedge clk);
    check("wd_err_sticky", timeout_err, 1);
`else
    stable = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || fifo_start !== 1'b0 || timeout_err !== 1'b0 ||
          out_valid !== 1'b0) stable = 1'b0;
    end
    check("unbounded_wait_holds", stable, 1);
    check("stall_tx_count", tx_count, exp_cnt);
`endif
    do_reset();
    freeze_at = 4'd15;
    check("err_cleared_by_reset", timeout_err, 0);

    // Counter wrap from a preloaded value.
    @(negedge clk);
    force dut.tx_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.tx_count_q;
    @(negedge clk);
    check("tx_count_preload", tx_count, 16'hFFFF);
    exp_cnt = 16'hFFFF;
    do_tx(16'($urandom), 0, 1'b0);
    check("tx_count_wrapped", tx_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
